// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: branch op encodings and the branch controller state.
package mips_pkg;

  localparam logic [3:0] OP_BEQ  = 4'b0000;
  localparam logic [3:0] OP_BNE  = 4'b0100;
  localparam logic [3:0] OP_BLEZ = 4'b0101;
  localparam logic [3:0] OP_BGTZ = 4'b0110;
  localparam logic [3:0] OP_BLTZ = 4'b0111;
  localparam logic [3:0] OP_BGEZ = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EVAL  = 2'd2,
    ST_REDIR = 2'd3
  } br_state_e;

  // Compare-against-zero branches only read rs, so rt readiness is irrelevant.
  function automatic logic is_single_op(input logic [3:0] op);
    return (op == OP_BLEZ) || (op == OP_BGTZ) || (op == OP_BLTZ) || (op == OP_BGEZ);
  endfunction

endpackage

// File: rtl/br_target_calc.sv
// Branch target adder: pc + 4 + (sign-extended offset << 2), wrapping modulo 2^32.
module br_target_calc (
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  output logic [31:0] target
);

  assign target = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: waits for forwarded operands, drives the external
// comparator, issues a one-cycle redirect with IF flush and keeps branch statistics.
module branch_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_branch,
  input  logic [3:0]       id_op,
  input  logic [31:0]      id_pc,
  input  logic [15:0]      id_imm,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             kill,
  input  logic             cmp_br,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  output logic [3:0]       cmp_op,
  output logic             stall,
  output logic             pc_sel,
  output logic [31:0]      br_target,
  output logic             flush_if,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  br_state_e   state_q, state_d;
  logic        ops_ready;
  logic        accept;
  logic        resolve;
  logic [31:0] target_calc;

  br_target_calc u_target (
    .pc     (id_pc),
    .imm    (id_imm),
    .target (target_calc)
  );

  assign ops_ready = rs_ready & (rt_ready | is_single_op(id_op));
  assign resolve   = (state_q == ST_EVAL) & ~kill;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (id_branch) begin
            accept  = ops_ready;
            state_d = ops_ready ? ST_EVAL : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // ID is held by stall; if the branch vanishes anyway, abandon it.
          if (!id_branch) begin
            state_d = ST_IDLE;
          end else if (ops_ready) begin
            accept  = 1'b1;
            state_d = ST_EVAL;
          end
        end
        ST_EVAL:  state_d = cmp_br ? ST_REDIR : ST_IDLE;
        ST_REDIR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      ST_IDLE:  stall = id_branch & ~kill;
      ST_WAIT:  stall = 1'b1;
      ST_EVAL:  stall = 1'b1;
      ST_REDIR: stall = 1'b0;
      default:  stall = 1'b0;
    endcase
  end

  // NOTE: the datapath registers are all reset (no memories here), so a reset
  // mid-branch leaves no pending redirect or stale target behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_a     <= '0;
      cmp_b     <= '0;
      cmp_op    <= '0;
      br_target <= '0;
      pc_sel    <= 1'b0;
      flush_if  <= 1'b0;
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      if (accept) begin
        cmp_a     <= rs_val;
        cmp_b     <= rt_val;
        cmp_op    <= id_op;
        br_target <= target_calc;
      end
      pc_sel   <= resolve & cmp_br;
      flush_if <= resolve & cmp_br;
      if (resolve) begin
        if (br_cnt != '1)
          br_cnt <= br_cnt + CNT_W'(1);
        if (cmp_br && taken_cnt != '1)
          taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with a behavioural comparator on the cmp_* outputs.
module tb_branch_ctrl;
  import mips_pkg::*;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_branch;
  logic [3:0]       id_op;
  logic [31:0]      id_pc;
  logic [15:0]      id_imm;
  logic             rs_ready, rt_ready;
  logic [31:0]      rs_val, rt_val;
  logic             kill;
  logic             cmp_br;
  logic [31:0]      cmp_a, cmp_b;
  logic [3:0]       cmp_op;
  logic             stall, pc_sel, flush_if;
  logic [31:0]      br_target;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  int passed = 0;
  int total  = 0;

  branch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .id_branch (id_branch),
    .id_op     (id_op),
    .id_pc     (id_pc),
    .id_imm    (id_imm),
    .rs_ready  (rs_ready),
    .rt_ready  (rt_ready),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .kill      (kill),
    .cmp_br    (cmp_br),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_op    (cmp_op),
    .stall     (stall),
    .pc_sel    (pc_sel),
    .br_target (br_target),
    .flush_if  (flush_if),
    .br_cnt    (br_cnt),
    .taken_cnt (taken_cnt)
  );

  always #5 clk = ~clk;

  // External comparator stand-in.
  function automatic logic cmp_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] op);
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLEZ: return $signed(a) <= 0;
      OP_BGTZ: return $signed(a) > 0;
      OP_BLTZ: return $signed(a) < 0;
      OP_BGEZ: return $signed(a) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  always_comb cmp_br = cmp_model(cmp_a, cmp_b, cmp_op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    id_branch = 1'b0;
    kill      = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic set_br(input logic [3:0] op, input logic [31:0] pc, input logic [15:0] imm,
                        input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic rsr, input logic rtr);
    id_branch = 1'b1;
    id_op     = op;
    id_pc     = pc;
    id_imm    = imm;
    rs_val    = rsv;
    rt_val    = rtv;
    rs_ready  = rsr;
    rt_ready  = rtr;
  endtask

  initial begin
    reset     = 1'b1;
    id_branch = 1'b0;
    id_op     = '0;
    id_pc     = '0;
    id_imm    = '0;
    rs_ready  = 1'b0;
    rt_ready  = 1'b0;
    rs_val    = '0;
    rt_val    = '0;
    kill      = 1'b0;

    // Reset state
    #3;
    check("rst_cmp_a", cmp_a, 32'h0);
    check("rst_cmp_b", cmp_b, 32'h0);
    check("rst_cmp_op", 32'(cmp_op), 32'h0);
    check("rst_target", br_target, 32'h0);
    check("rst_pc_sel", 32'(pc_sel), 32'h0);
    check("rst_flush", 32'(flush_if), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_br_cnt", 32'(br_cnt), 32'h0);
    check("rst_taken", 32'(taken_cnt), 32'h0);
    step();
    reset = 1'b0;

    // beq taken, both ready
    set_br(OP_BEQ, 32'h0040_0000, 16'h0003, 32'd5, 32'd5, 1'b1, 1'b1);
    #1 check("beq_stall_idle", 32'(stall), 32'h1);
    step();
    id_branch = 1'b0;
    check("beq_stall_eval", 32'(stall), 32'h1);
    check("beq_cmp_a", cmp_a, 32'd5);
    check("beq_pc_sel_n1", 32'(pc_sel), 32'h0);
    step();
    check("beq_pc_sel", 32'(pc_sel), 32'h1);
    check("beq_flush", 32'(flush_if), 32'h1);
    check("beq_target", br_target, 32'h0040_0010);
    check("beq_br_cnt", 32'(br_cnt), 32'h1);
    check("beq_taken", 32'(taken_cnt), 32'h1);
    check("beq_stall_redir", 32'(stall), 32'h0);
    step();
    check("beq_pc_sel_drop", 32'(pc_sel), 32'h0);

    // bne not taken
    do_reset();
    set_br(OP_BNE, 32'h0000_1000, 16'h0010, 32'd7, 32'd7, 1'b1, 1'b1);
    step();
    id_branch = 1'b0;
    check("bne_cmp_op", 32'(cmp_op), 32'(OP_BNE));
    step();
    check("bne_pc_sel", 32'(pc_sel), 32'h0);
    check("bne_idle", 32'(stall), 32'h0);
    check("bne_br_cnt", 32'(br_cnt), 32'h1);
    check("bne_taken", 32'(taken_cnt), 32'h0);

    // bgtz on a negative operand
    do_reset();
    set_br(OP_BGTZ, 32'h0000_2000, 16'h0004, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    step();
    id_branch = 1'b0;
    check("bgtz_eval", 32'(stall), 32'h1);
    step();
    check("bgtz_pc_sel", 32'(pc_sel), 32'h0);
    check("bgtz_br_cnt", 32'(br_cnt), 32'h1);
    check("bgtz_taken", 32'(taken_cnt), 32'h0);

    // beq with rt not ready for three cycles
    do_reset();
    set_br(OP_BEQ, 32'h0000_0100, 16'h0001, 32'd9, 32'd9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("wait_stall_%0d", i), 32'(stall), 32'h1);
      check($sformatf("wait_no_latch_%0d", i), cmp_b, 32'h0);
    end
    rt_ready = 1'b1;
    step();
    id_branch = 1'b0;
    check("wait_eval_stall", 32'(stall), 32'h1);
    check("wait_cmp_b", cmp_b, 32'd9);
    step();
    check("wait_pc_sel", 32'(pc_sel), 32'h1);
    check("wait_target", br_target, 32'h0000_0108);

    // bltz ignores rt_ready
    do_reset();
    set_br(OP_BLTZ, 32'h0000_2000, 16'hFFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    step();
    id_branch = 1'b0;
    check("bltz_cmp_op", 32'(cmp_op), 32'(OP_BLTZ));
    step();
    check("bltz_pc_sel", 32'(pc_sel), 32'h1);
    check("bltz_target", br_target, 32'h0000_2000);

    // Target wrap-around
    do_reset();
    set_br(OP_BEQ, 32'h0000_0000, 16'h8000, 32'd1, 32'd1, 1'b1, 1'b1);
    step();
    id_branch = 1'b0;
    step();
    check("wrap_pc_sel", 32'(pc_sel), 32'h1);
    check("wrap_target", br_target, 32'hFFFE_0004);

    // Unknown op resolves not-taken but is counted
    do_reset();
    set_br(4'b0011, 32'h0000_0400, 16'h0002, 32'd3, 32'd3, 1'b1, 1'b1);
    step();
    id_branch = 1'b0;
    step();
    check("unk_pc_sel", 32'(pc_sel), 32'h0);
    check("unk_br_cnt", 32'(br_cnt), 32'h1);
    check("unk_taken", 32'(taken_cnt), 32'h0);

    // kill masks stall in IDLE, then kill in WAIT
    do_reset();
    set_br(OP_BEQ, 32'h0000_0800, 16'h0001, 32'd4, 32'd4, 1'b1, 1'b0);
    kill = 1'b1;
    #1 check("kill_idle_stall", 32'(stall), 32'h0);
    step();
    kill = 1'b0;
    #1 check("kill_idle_stays", 32'(stall), 32'h1);
    step();
    check("killw_in_wait", 32'(stall), 32'h1);
    kill = 1'b1;
    step();
    kill      = 1'b0;
    id_branch = 1'b0;
    #1 check("killw_idle", 32'(stall), 32'h0);
    step();
    check("killw_pc_sel", 32'(pc_sel), 32'h0);
    check("killw_br_cnt", 32'(br_cnt), 32'h0);

    // kill in EVAL while the comparator says taken
    do_reset();
    set_br(OP_BEQ, 32'h0000_0800, 16'h0001, 32'd6, 32'd6, 1'b1, 1'b1);
    step();
    id_branch = 1'b0;
    check("kille_cmp_br", 32'(cmp_br), 32'h1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    #1 check("kille_pc_sel", 32'(pc_sel), 32'h0);
    check("kille_flush", 32'(flush_if), 32'h0);
    check("kille_idle", 32'(stall), 32'h0);
    check("kille_br_cnt", 32'(br_cnt), 32'h0);
    check("kille_taken", 32'(taken_cnt), 32'h0);

    // Counter saturation: five taken branches into 2-bit counters
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_br(OP_BEQ, 32'h0000_0000 + 32'(i * 16), 16'h0001, 32'd2, 32'd2, 1'b1, 1'b1);
      step();
      id_branch = 1'b0;
      step();
      step();
    end
    check("sat_br_cnt", 32'(br_cnt), 32'h3);
    check("sat_taken", 32'(taken_cnt), 32'h3);

    // Asynchronous reset in the middle of EVAL
    set_br(OP_BEQ, 32'h0000_3000, 16'h0002, 32'hAB, 32'hAB, 1'b1, 1'b1);
    step();
    id_branch = 1'b0;
    check("mid_eval_stall", 32'(stall), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_cmp_a", cmp_a, 32'h0);
    check("mid_rst_cmp_b", cmp_b, 32'h0);
    check("mid_rst_target", br_target, 32'h0);
    check("mid_rst_br_cnt", 32'(br_cnt), 32'h0);
    check("mid_rst_taken", 32'(taken_cnt), 32'h0);
    step();
    reset = 1'b0;
    step();
    check("mid_rst_no_redir", 32'(pc_sel), 32'h0);
    check("mid_rst_no_flush", 32'(flush_if), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequencing controller for the branch comparator in the ID stage of the pipelined MIPS core. It accepts a decoded branch and stalls the front end until both source operands are forwarded-ready. It latches them into the comparator, samples the comparator's taken result, and issues a one-cycle PC redirect with IF flush. It also keeps saturating branch/taken statistics counters.

## Interface
Parameters:
- CNT_W, 16, width of statistics counters

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high
- id_branch  input  1  valid branch instruction present in ID
- id_op  input  4  branch op: 0000 beq, 0100 bne, 0101 blez, 0110 bgtz, 0111 bltz, 1000 bgez
- id_pc  input  32  PC of the branch
- id_imm  input  16  branch offset field
- rs_ready, rt_ready  input  1 each  forwarded operand valid this cycle
- rs_val, rt_val  input  32 each  forwarded operand values
- kill  input  1  pipeline squash (exception); aborts any in-flight branch
- cmp_br  input  1  comparator taken output (combinational from cmp_a/cmp_b/cmp_op)
- cmp_a, cmp_b  output  32 each  registered comparator operands
- cmp_op  output  4  registered comparator op
- stall  output  1  hold PC and IF/ID
- pc_sel  output  1  one-cycle redirect strobe
- br_target  output  32  redirect address, valid when pc_sel=1
- flush_if  output  1  squash IF/ID, asserted with pc_sel
- br_cnt, taken_cnt  output  CNT_W each  resolved / taken branch counts

## Operation
- FSM states: IDLE, WAIT, EVAL, REDIR.
- IDLE:
  - id_branch & rs_ready & rt_ready: latch cmp_a=rs_val, cmp_b=rt_val, cmp_op=id_op, target -> EVAL.
  - id_branch & !ready: -> WAIT.
- WAIT: re-check ready each cycle using current ID inputs (held by stall); on ready, latch as above -> EVAL.
- EVAL: sample cmp_br; br_cnt++.
  - Taken: taken_cnt++, -> REDIR.
  - Not taken: -> IDLE.
- REDIR: pc_sel=1, flush_if=1 for exactly one cycle -> IDLE. A new branch may not be accepted in REDIR (ID content is being flushed).
- Target: id_pc + 4 + (sign_extend(id_imm) << 2), modulo 2^32; wrap-around is silent.
- Ops outside the six encodings: comparator yields 0 -> resolved not-taken; still counted in br_cnt.
- blez/bgtz/bltz/bgez use cmp_a only; rt_ready is ignored (treated as 1) for those ops.
- kill in any state: -> IDLE next edge; no redirect, no counter update; kill wins over taken in EVAL.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset values: state IDLE, cmp_a=cmp_b=0, cmp_op=0, br_target=0, pc_sel=0, flush_if=0, stall=0, counters 0.
- stall is combinational:
  - 1 in IDLE when id_branch is high and the branch is not killed.
  - 1 throughout WAIT and EVAL.
  - 0 in REDIR.
- pc_sel, flush_if and br_target are registered outputs.
- Ready branch accepted at cycle N: EVAL at N+1, pc_sel at N+2 (taken), IDLE at N+2 (not taken).
- Each WAIT cycle adds one cycle of latency.
- Reset asserted mid-operation clears everything asynchronously. No pending redirect survives.

## Structure
- Shared package mips_pkg: branch op encodings (OP_BEQ…OP_BGEZ) and the FSM state enum.
- cmp is instantiated outside; branch_ctrl drives it and reads cmp_br.
- One natural sub-module: br_target_calc (pure combinational target adder).

## Test plan
- beq, rs=rt=5, both ready, id_pc=0x00400000, imm=0x0003 → pc_sel at N+2, br_target=0x00400010, br_cnt=1, taken_cnt=1.
- bne, rs=rt=7 → no pc_sel, state IDLE at N+2, br_cnt=1, taken_cnt=0. Separately: bgtz with rs=0x80000000 → not taken.
- beq with rt_ready low for 3 cycles → stall high 3 extra cycles, then normal resolution. Separately: bltz with rt_ready low → no WAIT.
- imm=0x8000 with id_pc=0x00000000 → br_target=0xFFFE0004 (wrap).
- kill asserted in WAIT, and separately in EVAL with cmp_br=1 → no pc_sel, counters unchanged, IDLE next cycle.
- Counter saturation with CNT_W=2: 5 taken branches → br_cnt=taken_cnt=3. Reset pulsed mid-EVAL → all outputs at reset values immediately.
